// File: rtl/cei_mochila_pkg.sv
// Shared types and constants for the TMR data-bus voter.
//   tmr_voter_state_e : voter FSM states
//   TMR_SKEW_MAX      : default request skew window in cycles
//   TMR_ERR_CNT_W     : width of the corrected-mismatch counter
package cei_mochila_pkg;

  typedef enum logic [2:0] {
    VOTER_IDLE,
    VOTER_GATHER,
    VOTER_ISSUE,
    VOTER_WAIT_RSP,
    VOTER_ERROR
  } tmr_voter_state_e;

  localparam int unsigned TMR_SKEW_MAX  = 4;
  localparam int unsigned TMR_ERR_CNT_W = 16;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the CPU data ports and the system bus.
//   obi_req_t  : req, addr[31:0], we, be[3:0], wdata[31:0]
//   obi_resp_t : gnt, rvalid, rdata[31:0]
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/tmr_majority3.sv
// Bitwise 2-of-3 majority voter for one field.
//   a, b, c : the three replicas of the field
//   y       : bitwise majority
//   dis     : dis[i] set when replica i differs from y anywhere
//   no_maj  : all three replicas pairwise different (no trustworthy value)
module tmr_majority3 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic [2:0]   dis,
  output logic         no_maj
);

  assign y      = (a & b) | (a & c) | (b & c);
  assign dis    = {c != y, b != y, a != y};
  // The bitwise vote always yields something, but if no two replicas agree
  // on the whole field the result is a synthetic value nobody asked for.
  assign no_maj = (a != b) && (a != c) && (b != c);

endmodule

// File: rtl/tmr_obi_voter.sv
// TMR OBI data-bus voter: gathers the three harts' requests inside a skew
// window, votes address/we/be/wdata, issues one bus transaction and
// broadcasts grant and response back to all harts.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   enable_i          : 1 = voting, 0 = hart 0 pass-through (sampled in IDLE)
//   clear_i           : clears sticky status, leaves ERROR
//   hart_req_i/resp_o : per-hart OBI data ports
//   bus_req_o/resp_i  : voted OBI port to the system bus
//   mismatch_o        : pulse on a corrected 2-of-3 disagreement
//   faulty_hart_o     : sticky one-hot of disagreeing harts
//   skew_err_o        : sticky, skew window expired
//   vote_err_o        : sticky, no majority on some field
//   err_cnt_o         : corrected-mismatch count
// Optional: TMR_VOTER_ERR_CNT_EN builds the saturating mismatch counter;
// without it err_cnt_o is tied to 0.
module tmr_obi_voter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned SKEW_MAX = TMR_SKEW_MAX,
  parameter int unsigned NHARTS   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  obi_req_t  [NHARTS-1:0]   hart_req_i,
  output obi_resp_t [NHARTS-1:0]   hart_resp_o,
  output obi_req_t                 bus_req_o,
  input  obi_resp_t                bus_resp_i,
  output logic                     mismatch_o,
  output logic [2:0]               faulty_hart_o,
  output logic                     skew_err_o,
  output logic                     vote_err_o,
  output logic [TMR_ERR_CNT_W-1:0] err_cnt_o
);

  if (NHARTS != 3) begin : g_nharts_chk
    $error("tmr_obi_voter: NHARTS must be 3");
  end
  if (SKEW_MAX < 1 || SKEW_MAX > 255) begin : g_skew_chk
    $error("tmr_obi_voter: SKEW_MAX must be 1..255");
  end

  localparam logic [7:0] SKEW_LIM = 8'(SKEW_MAX);

  tmr_voter_state_e state_q, state_d;
  logic [7:0] skew_cnt_q, skew_d;
  obi_req_t   voted, voted_q;
  logic       mismatch_q, skew_err_q, vote_err_q;
  logic [2:0] faulty_q, new_fault;
  logic       tmr_mode_q, tmr_act, pt_out_q;
  logic       all_req, any_req, snap, set_skew, set_vote;

  // ---- field voters, fed straight from the hart ports so a vote failure
  // is known at the snapshot edge and nothing reaches the bus
  logic [31:0] v_addr, v_wdata;
  logic [3:0]  v_be;
  logic        v_we;
  logic [2:0]  dis_addr, dis_we, dis_be, dis_wdata;
  logic        nm_addr, nm_we, nm_be, nm_wdata, vote_fail;

  tmr_majority3 #(.W(32)) u_vote_addr (
    .a(hart_req_i[0].addr), .b(hart_req_i[1].addr), .c(hart_req_i[2].addr),
    .y(v_addr), .dis(dis_addr), .no_maj(nm_addr));
  tmr_majority3 #(.W(1)) u_vote_we (
    .a(hart_req_i[0].we), .b(hart_req_i[1].we), .c(hart_req_i[2].we),
    .y(v_we), .dis(dis_we), .no_maj(nm_we));
  tmr_majority3 #(.W(4)) u_vote_be (
    .a(hart_req_i[0].be), .b(hart_req_i[1].be), .c(hart_req_i[2].be),
    .y(v_be), .dis(dis_be), .no_maj(nm_be));
  tmr_majority3 #(.W(32)) u_vote_wdata (
    .a(hart_req_i[0].wdata), .b(hart_req_i[1].wdata), .c(hart_req_i[2].wdata),
    .y(v_wdata), .dis(dis_wdata), .no_maj(nm_wdata));

  assign vote_fail = nm_addr | nm_we | nm_be | nm_wdata;
  assign voted     = '{req: 1'b1, addr: v_addr, we: v_we, be: v_be, wdata: v_wdata};
  assign new_fault = (snap && !vote_fail) ? (dis_addr | dis_we | dis_be | dis_wdata) : 3'b000;

  assign all_req = hart_req_i[0].req & hart_req_i[1].req & hart_req_i[2].req;
  assign any_req = hart_req_i[0].req | hart_req_i[1].req | hart_req_i[2].req;

  // Mode follows enable_i only while idle with no pass-through response
  // still owed to hart 0; otherwise the latched mode holds.
  assign tmr_act = (state_q == VOTER_IDLE && !pt_out_q) ? enable_i : tmr_mode_q;

  // ---- next state
  always_comb begin
    state_d  = state_q;
    skew_d   = skew_cnt_q;
    snap     = 1'b0;
    set_skew = 1'b0;
    set_vote = 1'b0;
    case (state_q)
      VOTER_IDLE: begin
        if (tmr_act) begin
          if (all_req) begin
            snap = 1'b1;
          end else if (any_req) begin
            state_d = VOTER_GATHER;
            skew_d  = 8'd1;
          end
        end
      end
      VOTER_GATHER: begin
        // The window closes once the count reaches SKEW_MAX: a last arrival
        // at cycle k is accepted only for k < SKEW_MAX.
        if (skew_cnt_q >= SKEW_LIM) begin
          set_skew = 1'b1;
          state_d  = VOTER_ERROR;
        end else if (all_req) begin
          snap = 1'b1;
        end else begin
          skew_d = skew_cnt_q + 8'd1;
        end
      end
      VOTER_ISSUE:    if (bus_resp_i.gnt)    state_d = VOTER_WAIT_RSP;
      VOTER_WAIT_RSP: if (bus_resp_i.rvalid) state_d = VOTER_IDLE;
      VOTER_ERROR:    if (clear_i)           state_d = VOTER_IDLE;
      default:        state_d = VOTER_IDLE;
    endcase
    if (snap) begin
      if (vote_fail) begin
        set_vote = 1'b1;
        state_d  = VOTER_ERROR;
      end else begin
        state_d  = VOTER_ISSUE;
      end
    end
  end

  // ---- state and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= VOTER_IDLE;
      skew_cnt_q <= '0;
      voted_q    <= '0;
      mismatch_q <= 1'b0;
      faulty_q   <= '0;
      skew_err_q <= 1'b0;
      vote_err_q <= 1'b0;
      tmr_mode_q <= 1'b0;
      pt_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_d;
      tmr_mode_q <= tmr_act;
      if (snap && !vote_fail) voted_q <= voted;
      mismatch_q <= |new_fault;
      // A fault detected in the same cycle as clear_i is kept.
      faulty_q   <= (clear_i ? 3'b000 : faulty_q) | new_fault;
      skew_err_q <= (skew_err_q & ~clear_i) | set_skew;
      vote_err_q <= (vote_err_q & ~clear_i) | set_vote;
      if (!tmr_act)
        pt_out_q <= (pt_out_q & ~bus_resp_i.rvalid) | (hart_req_i[0].req & bus_resp_i.gnt);
    end
  end

`ifdef TMR_VOTER_ERR_CNT_EN
  logic [TMR_ERR_CNT_W-1:0] err_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)
      err_cnt_q <= '0;
    else if (|new_fault && err_cnt_q != '1)
      err_cnt_q <= err_cnt_q + 1'b1;
  end
  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  // ---- datapath outputs
  always_comb begin
    bus_req_o   = '0;
    hart_resp_o = '0;
    if (!tmr_act) begin
      bus_req_o      = hart_req_i[0];
      hart_resp_o[0] = bus_resp_i;
    end else begin
      case (state_q)
        VOTER_ISSUE: begin
          bus_req_o     = voted_q;
          bus_req_o.req = 1'b1;
          for (int i = 0; i < NHARTS; i++) hart_resp_o[i].gnt = bus_resp_i.gnt;
        end
        VOTER_WAIT_RSP: begin
          for (int i = 0; i < NHARTS; i++) begin
            hart_resp_o[i].rvalid = bus_resp_i.rvalid;
            hart_resp_o[i].rdata  = bus_resp_i.rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mismatch_o    = mismatch_q;
  assign faulty_hart_o = faulty_q;
  assign skew_err_o    = skew_err_q;
  assign vote_err_o    = vote_err_q;

endmodule

// File: tb/tb_tmr_obi_voter.sv
// Scoreboard bench for tmr_obi_voter: directed transactions push expected
// bus requests and hart responses; a monitor pops and compares them.
module tb_tmr_obi_voter;
  import obi_pkg::*;
  import cei_mochila_pkg::*;

  logic clk = 1'b0;
  logic rst, enable, clear;
  obi_req_t  [2:0] hart_req;
  obi_resp_t [2:0] hart_resp;
  obi_req_t        bus_req;
  obi_resp_t       bus_resp;
  logic            mismatch, skew_err, vote_err;
  logic [2:0]      faulty;
  logic [15:0]     err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { obi_req_t req; logic [2:0] gnt_mask; } exp_bus_t;
  typedef struct { logic [2:0] mask; logic [31:0] rdata; } exp_rsp_t;
  exp_bus_t exp_bus_q[$];
  exp_rsp_t exp_rsp_q[$];

  logic [31:0] bus_rdata;
  bit          hold_rsp;

`ifdef TMR_VOTER_ERR_CNT_EN
  localparam logic [15:0] CNT_ONE = 16'd1;
`else
  localparam logic [15:0] CNT_ONE = 16'd0;
`endif

  tmr_obi_voter #(.SKEW_MAX(TMR_SKEW_MAX), .NHARTS(3)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .hart_req_i(hart_req), .hart_resp_o(hart_resp),
    .bus_req_o(bus_req), .bus_resp_i(bus_resp),
    .mismatch_o(mismatch), .faulty_hart_o(faulty),
    .skew_err_o(skew_err), .vote_err_o(vote_err), .err_cnt_o(err_cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obi_req_t mk(input logic [31:0] a, input logic we,
                                  input logic [3:0] be, input logic [31:0] wd);
    obi_req_t r;
    r = '{req: 1'b1, addr: a, we: we, be: be, wdata: wd};
    return r;
  endfunction

  task automatic push_bus(input obi_req_t r, input logic [2:0] m);
    exp_bus_t e;
    e.req = r; e.gnt_mask = m;
    exp_bus_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [2:0] m, input logic [31:0] d);
    exp_rsp_t e;
    e.mask = m; e.rdata = d;
    exp_rsp_q.push_back(e);
  endtask

  // Bus slave: one wait cycle before gnt, rvalid the cycle after gnt.
  initial begin
    bit rsp_due;
    int hold;
    rsp_due = 0; hold = 0;
    bus_resp = '0;
    forever begin
      @(posedge clk); #2;
      bus_resp = '0;
      if (rsp_due && !hold_rsp) begin
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = bus_rdata;
        rsp_due = 0;
      end else if (bus_req.req && !rsp_due) begin
        if (hold >= 1) begin
          bus_resp.gnt = 1'b1; hold = 0; rsp_due = 1;
        end else hold++;
      end
    end
  end

  // Monitor: pops the scoreboard on every bus handshake and hart response.
  initial begin
    exp_bus_t   eb;
    exp_rsp_t   er;
    logic [2:0] gm, rv;
    forever begin
      @(negedge clk);
      if (!rst && bus_req.req && bus_resp.gnt) begin
        gm = {hart_resp[2].gnt, hart_resp[1].gnt, hart_resp[0].gnt};
        if (exp_bus_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected bus txn: addr %0h gnt %b, none expected", bus_req.addr, gm);
        end else begin
          eb = exp_bus_q.pop_front();
          check("bus addr",  bus_req.addr,  eb.req.addr);
          check("bus we/be", {bus_req.we, bus_req.be}, {eb.req.we, eb.req.be});
          check("bus wdata", bus_req.wdata, eb.req.wdata);
          check("hart gnt mask", gm, eb.gnt_mask);
        end
      end
      rv = {hart_resp[2].rvalid, hart_resp[1].rvalid, hart_resp[0].rvalid};
      if (!rst && rv != 3'b000) begin
        if (exp_rsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected hart rvalid: mask %b, none expected", rv);
        end else begin
          er = exp_rsp_q.pop_front();
          check("rvalid mask", rv, er.mask);
          for (int i = 0; i < 3; i++)
            if (er.mask[i]) check($sformatf("hart%0d rdata", i), hart_resp[i].rdata, er.rdata);
        end
      end
    end
  end

  // Drives one transaction; each hart raises its request at cycle d<h> and
  // drops it after its grant. exp_lat = cycle of first bus req (-1: none).
  task automatic run_txn(input string name, input obi_req_t r0, input obi_req_t r1,
                         input obi_req_t r2, input int d0, input int d1, input int d2,
                         input int exp_lat, input int exp_mm, input bit expect_rsp,
                         input int budget);
    obi_req_t   r[3];
    int         dly[3];
    logic [2:0] gseen;
    int first_req, mm, mm_cyc, cyc;
    bit done;
    r[0] = r0; r[1] = r1; r[2] = r2;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    gseen = '0; first_req = -1; mm = 0; mm_cyc = -1; cyc = 0; done = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      for (int h = 0; h < 3; h++) begin
        if (gseen[h]) hart_req[h] = '0;
        else if (cyc == dly[h]) hart_req[h] = r[h];
      end
      @(negedge clk);
      if (bus_req.req && first_req < 0) first_req = cyc;
      if (mismatch) begin mm++; if (mm_cyc < 0) mm_cyc = cyc; end
      for (int h = 0; h < 3; h++) if (hart_resp[h].gnt) gseen[h] = 1'b1;
      if (expect_rsp && hart_resp[0].rvalid) done = 1;
      cyc++;
    end
    @(posedge clk); #1;
    hart_req = '0;
    check({name, " first bus req cycle"}, first_req, exp_lat);
    check({name, " mismatch pulses"}, mm, exp_mm);
    if (exp_mm > 0) check({name, " mismatch cycle"}, mm_cyc, exp_lat);
    if (expect_rsp) check({name, " completed"}, done, 1'b1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obi_req_t w, wbad, rd, ra, rb, rc, rx;
    bit got;
    rst = 1'b1; enable = 1'b1; clear = 1'b0; hart_req = '0;
    bus_rdata = '0; hold_rsp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset bus_req", bus_req, '0);
    check("reset hart_resp", hart_resp, '0);
    check("reset flags", {mismatch, faulty, skew_err, vote_err}, '0);
    check("reset err_cnt", err_cnt, '0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: aligned identical writes
    w = mk(32'h2000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
    bus_rdata = '0;
    push_bus(w, 3'b111); push_rsp(3'b111, 32'h0);
    run_txn("aligned", w, w, w, 0, 0, 0, 1, 0, 1, 12);
    check("aligned faulty", faulty, 3'b000);

    // 2: hart 2 corrupt wdata, corrected by vote
    wbad = mk(32'h2000_0010, 1'b1, 4'hF, 32'hDEAD_BEEE);
    push_bus(w, 3'b111); push_rsp(3'b111, 32'h0);
    run_txn("hart2 wdata", w, w, wbad, 0, 0, 0, 1, 1, 1, 12);
    check("hart2 faulty", faulty, 3'b100);
    check("hart2 err_cnt", err_cnt, CNT_ONE);
    pulse_clear();
    @(negedge clk);
    check("clear faulty", faulty, 3'b000);
    check("clear err_cnt", err_cnt, 16'd0);

    // 3: hart 1 three cycles late: still inside the window
    rd = mk(32'h2000_0100, 1'b0, 4'hF, 32'h0);
    bus_rdata = 32'hCAFE_F00D;
    push_bus(rd, 3'b111); push_rsp(3'b111, 32'hCAFE_F00D);
    run_txn("skew3", rd, rd, rd, 0, 3, 0, 4, 0, 1, 16);
    check("skew3 skew_err", skew_err, 1'b0);

    // 4: hart 1 four cycles late: window expired
    run_txn("skew4", rd, rd, rd, 0, 4, 0, -1, 0, 0, 10);
    @(negedge clk);
    check("skew4 skew_err", skew_err, 1'b1);
    check("skew4 vote_err", vote_err, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("skew4 bus idle in error", bus_req.req, 1'b0);
    pulse_clear();
    @(negedge clk);
    check("skew4 cleared", {skew_err, vote_err, faulty}, '0);

    // 5: three different addresses: no majority
    ra = mk(32'h0000_0100, 1'b0, 4'hF, 32'h0);
    rb = mk(32'h0000_0200, 1'b0, 4'hF, 32'h0);
    rc = mk(32'h0000_0400, 1'b0, 4'hF, 32'h0);
    run_txn("novote", ra, rb, rc, 0, 0, 0, -1, 0, 0, 6);
    @(negedge clk);
    check("novote vote_err", vote_err, 1'b1);
    check("novote skew_err", skew_err, 1'b0);
    pulse_clear();
    @(negedge clk);
    check("novote cleared", {skew_err, vote_err, faulty, mismatch}, '0);

    // 6: pass-through, harts 1/2 request but are never served
    @(posedge clk); #1; enable = 1'b0;
    rx = mk(32'h0000_1000, 1'b0, 4'hF, 32'h0);
    bus_rdata = 32'h1234_5678;
    push_bus(rx, 3'b001); push_rsp(3'b001, 32'h1234_5678);
    run_txn("passthru", rx, rx, rx, 0, 0, 0, 0, 0, 1, 12);
    enable = 1'b1;
    repeat (2) @(posedge clk);

    // 7: reset while waiting for rvalid; the stale rvalid must not leak
    hold_rsp = 1;
    rx = mk(32'h2000_0040, 1'b0, 4'hF, 32'h0);
    wbad = mk(32'h2000_0040, 1'b0, 4'h3, 32'h0);
    push_bus(rx, 3'b111);
    @(posedge clk); #1;
    hart_req[0] = rx; hart_req[1] = wbad; hart_req[2] = rx;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (hart_resp[0].gnt) begin got = 1; break; end
    end
    check("rst txn granted", got, 1'b1);
    @(posedge clk); #1; hart_req = '0;
    @(negedge clk);
    check("rst txn faulty", faulty, 3'b010);
    check("rst txn err_cnt", err_cnt, CNT_ONE);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post-rst bus_req", bus_req, '0);
    check("post-rst hart_resp", hart_resp, '0);
    check("post-rst flags", {mismatch, faulty, skew_err, vote_err}, '0);
    check("post-rst err_cnt", err_cnt, '0);
    hold_rsp = 0;
    repeat (4) @(posedge clk);

    // 8: normal aligned read after reset
    rd = mk(32'h2000_0080, 1'b0, 4'hF, 32'h0);
    bus_rdata = 32'h0BAD_F00D;
    push_bus(rd, 3'b111); push_rsp(3'b111, 32'h0BAD_F00D);
    run_txn("after rst", rd, rd, rd, 0, 0, 0, 1, 0, 1, 12);
    check("after rst faulty", faulty, 3'b000);

    repeat (3) @(posedge clk);
    check("bus scoreboard drained", exp_bus_q.size(), 0);
    check("rsp scoreboard drained", exp_rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
